// File: rtl/cache_set_ctrl.sv
// N-way set-associative tag/state controller with true-LRU replacement,
// write-back dirty tracking and saturating hit/miss statistics.
module cache_set_ctrl #(
  parameter int WAYS       = 4,
  parameter int SETS       = 256,
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int CNT_W      = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ADDR_W-1:0]        cmd_addr,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [1:0]               resp_bus,
  output logic [$clog2(WAYS)-1:0]  resp_way,
  output logic [ADDR_W-1:0]        resp_victim_addr,
  output logic [CNT_W-1:0]         stat_reads,
  output logic [CNT_W-1:0]         stat_writes,
  output logic [CNT_W-1:0]         stat_hits,
  output logic [CNT_W-1:0]         stat_misses,
  output logic [1:0]               state_dbg
);
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W    = $clog2(WAYS);

  localparam logic [1:0] OP_RESET = 2'd0, OP_INV = 2'd1, OP_READ = 2'd2, OP_WRITE = 2'd3;
  localparam logic [1:0] BUS_READ = 2'd0, BUS_WRITE = 2'd1, BUS_RW = 2'd2, BUS_NOP = 2'd3;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_RESP} state_t;

  state_t                  state_q;
  logic [INDEX_W-1:0]      clr_idx_q;
  logic                    rst_pend_q;
  logic [1:0]              op_q;
  logic [TAG_W-1:0]        req_tag_q;
  logic [INDEX_W-1:0]      req_idx_q;
  logic                    hit_q;
  logic [WAY_W-1:0]        way_q;

  logic [WAYS-1:0]                   valid_q [SETS];
  logic [WAYS-1:0]                   dirty_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0]        tag_q   [SETS];
  logic [WAYS-1:0][WAY_W-1:0]        age_q   [SETS];

  logic                    hit, inv_found;
  logic [WAY_W-1:0]        hit_way, inv_way, lru_way, vic_way;
  logic                    lk_hit;
  logic [1:0]              lk_bus;
  logic [WAY_W-1:0]        lk_way;
  logic [ADDR_W-1:0]       lk_vic;
  logic [WAYS-1:0][WAY_W-1:0] age_cur, age_upd, age_rst;

  logic unused_offset;
  assign unused_offset = ^cmd_addr[OFFSET_W-1:0];
  assign state_dbg     = state_q;

  // Tag compare and victim choice for the latched request; only meaningful in LOOKUP.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_idx_q][w] && tag_q[req_idx_q][w] == req_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[req_idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[req_idx_q][w] == WAY_W'(WAYS-1)) lru_way = WAY_W'(w);
    end
    vic_way = inv_found ? inv_way : lru_way;

    lk_hit = hit;
    lk_bus = BUS_NOP;
    lk_way = '0;
    lk_vic = '0;
    if (op_q == OP_INV) begin
      if (hit) begin
        lk_way = hit_way;
        if (dirty_q[req_idx_q][hit_way]) begin
          lk_bus = BUS_WRITE;
          lk_vic = {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
        end
      end
    end else if (hit) begin
      lk_way = hit_way;
    end else begin
      lk_way = vic_way;
      if (valid_q[req_idx_q][vic_way] && dirty_q[req_idx_q][vic_way]) begin
        lk_bus = BUS_RW;
        lk_vic = {tag_q[req_idx_q][vic_way], req_idx_q, {OFFSET_W{1'b0}}};
      end else begin
        lk_bus = BUS_READ;
      end
    end
  end

  // Ages younger than the touched way shift one step older; the touched way becomes MRU.
  always_comb begin
    age_cur = age_q[req_idx_q];
    for (int w = 0; w < WAYS; w++) begin
      age_rst[w] = WAY_W'(w);
      age_upd[w] = (age_cur[w] < age_cur[way_q]) ? age_cur[w] + WAY_W'(1) : age_cur[w];
    end
    age_upd[way_q] = '0;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and cmd_valid is ignored everywhere else.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_CLEAR;
      clr_idx_q        <= '0;
      rst_pend_q       <= 1'b0;
      op_q             <= OP_READ;
      req_tag_q        <= '0;
      req_idx_q        <= '0;
      hit_q            <= 1'b0;
      way_q            <= '0;
      cmd_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_bus         <= BUS_NOP;
      resp_way         <= '0;
      resp_victim_addr <= '0;
      stat_reads       <= '0;
      stat_writes      <= '0;
      stat_hits        <= '0;
      stat_misses      <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          valid_q[clr_idx_q] <= '0;
          dirty_q[clr_idx_q] <= '0;
          age_q[clr_idx_q]   <= age_rst;
          clr_idx_q          <= clr_idx_q + INDEX_W'(1);
          if (clr_idx_q == INDEX_W'(SETS-1)) begin
            if (rst_pend_q) begin
              state_q          <= S_RESP;
              resp_valid       <= 1'b1;
              resp_hit         <= 1'b0;
              resp_bus         <= BUS_NOP;
              resp_way         <= '0;
              resp_victim_addr <= '0;
            end else begin
              state_q   <= S_IDLE;
              cmd_ready <= 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            req_tag_q <= cmd_addr[ADDR_W-1 -: TAG_W];
            req_idx_q <= cmd_addr[OFFSET_W +: INDEX_W];
            cmd_ready <= 1'b0;
            if (cmd_op == OP_RESET) begin
              state_q     <= S_CLEAR;
              clr_idx_q   <= '0;
              rst_pend_q  <= 1'b1;
              stat_reads  <= '0;
              stat_writes <= '0;
              stat_hits   <= '0;
              stat_misses <= '0;
            end else begin
              state_q <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          resp_valid       <= 1'b1;
          resp_hit         <= lk_hit;
          resp_bus         <= lk_bus;
          resp_way         <= lk_way;
          resp_victim_addr <= lk_vic;
          hit_q            <= lk_hit;
          way_q            <= lk_way;
          state_q          <= S_RESP;
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          cmd_ready  <= 1'b1;
          state_q    <= S_IDLE;
          if (rst_pend_q) begin
            rst_pend_q <= 1'b0;
          end else if (op_q == OP_INV) begin
            if (hit_q) begin
              valid_q[req_idx_q][way_q] <= 1'b0;
              dirty_q[req_idx_q][way_q] <= 1'b0;
            end
          end else begin
            valid_q[req_idx_q][way_q] <= 1'b1;
            tag_q[req_idx_q][way_q]   <= req_tag_q;
            if (op_q == OP_WRITE)  dirty_q[req_idx_q][way_q] <= 1'b1;
            else if (!hit_q)       dirty_q[req_idx_q][way_q] <= 1'b0;
            age_q[req_idx_q] <= age_upd;
            if (op_q == OP_READ) stat_reads  <= sat_inc(stat_reads);
            else                 stat_writes <= sat_inc(stat_writes);
            if (hit_q)           stat_hits   <= sat_inc(stat_hits);
            else                 stat_misses <= sat_inc(stat_misses);
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end
endmodule
